// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: steps the decoder select through channels with blanking gaps and per-channel dwell.
// Optional feature macro SCAN_MASK_EN adds a channel mask input that skips disabled channels.
module decoder_scan_sequencer #(
    parameter int SEL_W        = 3,
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic [DWELL_W-1:0]  dwell,
`ifdef SCAN_MASK_EN
    input  logic [2**SEL_W-1:0] mask,
`endif
    output logic [SEL_W-1:0]    a,
    output logic                en,
    output logic                busy,
    output logic                ch_strobe,
    output logic                done
);
    localparam int N  = 2**SEL_W;
    localparam int CW = DWELL_W > 4 ? DWELL_W : 4;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [SEL_W-1:0] a_d, first, nxt, go_a;
    logic any, has_nxt, go, strobe_d, done_d;
    logic [N-1:0] m;
`ifdef SCAN_MASK_EN
    assign m = mask;
`else
    assign m = '1;
`endif
    assign any = |m;
    // lowest enabled channel, and the lowest enabled channel above the current one
    always_comb begin
        first   = '0;
        nxt     = '0;
        has_nxt = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) first = SEL_W'(i);
            if (m[i] && SEL_W'(i) > a) begin
                nxt     = SEL_W'(i);
                has_nxt = 1'b1;
            end
        end
    end
    always_comb begin
        state_d  = state;
        a_d      = a;
        cnt_d    = cnt;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        go       = 1'b0;
        go_a     = '0;
        case (state)
            IDLE: begin
                go   = start && any;
                go_a = first;
            end
            BLANK: begin
                cnt_d = cnt - 1'b1;
                if (cnt == '0) begin
                    state_d  = DRIVE;
                    cnt_d    = CW'(dwell);
                    strobe_d = 1'b1;
                end
            end
            DRIVE: begin
                cnt_d = cnt - 1'b1;
                if (cnt == '0) begin
                    go   = has_nxt || (continuous && any);
                    go_a = has_nxt ? nxt : first;
                    if (!go) begin
                        state_d = IDLE;
                        a_d     = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (go) begin
            a_d      = go_a;
            state_d  = BLANK_CYCLES == 0 ? DRIVE : BLANK;
            cnt_d    = BLANK_CYCLES == 0 ? CW'(dwell) : BLANK_LAST;
            strobe_d = BLANK_CYCLES == 0;
        end
        // abort wins over start and over channel advance
        if (stop) begin
            state_d  = IDLE;
            a_d      = '0;
            cnt_d    = '0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a         <= '0;
            cnt       <= '0;
            en        <= 1'b0;
            busy      <= 1'b0;
            ch_strobe <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            a         <= a_d;
            cnt       <= cnt_d;
            en        <= state_d == DRIVE;
            busy      <= state_d != IDLE;
            ch_strobe <= strobe_d;
            done      <= done_d;
        end
    end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: vector table plus channel-level sequences, checked through an expectation queue.
module tb_decoder_scan_sequencer;
    localparam int B = 1;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, continuous = 1'b0;
    logic [7:0] dwell = 8'd0;
`ifdef SCAN_MASK_EN
    logic [7:0] mask = 8'hff;
`endif
    logic [2:0] a;
    logic en, busy, ch_strobe, done;
    int checks = 0, errors = 0;
    typedef struct packed {logic [2:0] a; logic en; logic busy; logic strb; logic done;} obs_t;
    typedef struct {logic st; logic sp; logic cn; logic [7:0] dw; obs_t e;} vec_t;
    localparam obs_t IDL = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    obs_t q[$];
    vec_t tbl[12];

    decoder_scan_sequencer #(.SEL_W(3), .DWELL_W(8), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous), .dwell(dwell),
`ifdef SCAN_MASK_EN
        .mask(mask),
`endif
        .a(a), .en(en), .busy(busy), .ch_strobe(ch_strobe), .done(done)
    );

    always #5 clk = ~clk;

    function automatic obs_t ob(input logic [2:0] x, input logic e, input logic b, input logic s, input logic d);
        ob = '{x, e, b, s, d};
    endfunction

    task automatic compare(input string nm, input obs_t e);
        obs_t g;
        g = '{a, en, busy, ch_strobe, done};
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got a=%0d en=%b busy=%b strobe=%b done=%b, expected a=%0d en=%b busy=%b strobe=%b done=%b",
                     nm, g.a, g.en, g.busy, g.strb, g.done, e.a, e.en, e.busy, e.strb, e.done);
        end
    endtask

    task automatic cyc(input string nm, input logic st, input logic sp, input logic cn, input logic [7:0] dw, input obs_t e);
        start = st; stop = sp; continuous = cn; dwell = dw;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare(nm, q.pop_front());
    endtask

    // one channel: blank, strobed first drive (dwell dl latched), dl further drive cycles with dwell input da
    task automatic chan(input string nm, input logic st, input logic [2:0] ch, input logic [7:0] dl, input logic [7:0] da, input logic cn);
        for (int i = 0; i < B; i++) cyc(nm, st, 1'b0, cn, dl, ob(ch, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(nm, st, 1'b0, cn, dl, ob(ch, 1'b1, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < int'(dl); i++) cyc(nm, st, 1'b0, cn, da, ob(ch, 1'b1, 1'b1, 1'b0, 1'b0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'd0, IDL};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'd0, IDL};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'd0, ob(3'd0, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'd0, ob(3'd0, 1'b1, 1'b1, 1'b1, 1'b0)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, ob(3'd1, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd0, IDL};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'd1, ob(3'd0, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'd1, ob(3'd0, 1'b1, 1'b1, 1'b1, 1'b0)};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'd1, ob(3'd0, 1'b1, 1'b1, 1'b0, 1'b0)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'd1, ob(3'd1, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'd1, IDL};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'd1, IDL};
        #2 rst = 1'b1;
        @(negedge clk);
        compare("reset_state", IDL);
        rst = 1'b0;
        for (int i = 0; i < 12; i++)
            cyc($sformatf("vec%0d", i), tbl[i].st, tbl[i].sp, tbl[i].cn, tbl[i].dw, tbl[i].e);
        // single shot, dwell=2: 32 busy cycles then one done pulse
        for (int c = 0; c < 8; c++) chan($sformatf("single_ch%0d", c), c == 0, 3'(c), 8'd2, 8'd2, 1'b0);
        cyc("single_done", 1'b0, 1'b0, 1'b0, 8'd2, ob(3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc("single_idle", 1'b0, 1'b0, 1'b0, 8'd2, IDL);
        // continuous, dwell=0: wrap after channel 7, drop continuous during second-lap channel 5
        for (int c = 0; c < 16; c++) chan($sformatf("cont_ch%0d", c), c == 0, 3'(c % 8), 8'd0, 8'd0, c < 13);
        cyc("cont_done", 1'b0, 1'b0, 1'b0, 8'd0, ob(3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc("cont_idle", 1'b0, 1'b0, 1'b0, 8'd0, IDL);
        // stop during channel 4 drive
        for (int c = 0; c < 4; c++) chan($sformatf("stop_ch%0d", c), c == 0, 3'(c), 8'd1, 8'd1, 1'b0);
        cyc("stop_blank4", 1'b0, 1'b0, 1'b0, 8'd1, ob(3'd4, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("stop_drive4", 1'b0, 1'b0, 1'b0, 8'd1, ob(3'd4, 1'b1, 1'b1, 1'b1, 1'b0));
        cyc("stop_abort", 1'b0, 1'b1, 1'b0, 8'd1, IDL);
        cyc("stop_nodone", 1'b0, 1'b0, 1'b0, 8'd1, IDL);
        cyc("stop_idle", 1'b0, 1'b0, 1'b0, 8'd1, IDL);
        // dwell 1 -> 4 mid channel 0, start pulsed while busy on channel 2
        chan("dw_ch0", 1'b1, 3'd0, 8'd1, 8'd4, 1'b0);
        chan("dw_ch1", 1'b0, 3'd1, 8'd4, 8'd4, 1'b0);
        chan("busy_start_ch2", 1'b1, 3'd2, 8'd4, 8'd4, 1'b0);
        for (int c = 3; c < 8; c++) chan($sformatf("dw_ch%0d", c), 1'b0, 3'(c), 8'd4, 8'd4, 1'b0);
        cyc("dw_done", 1'b0, 1'b0, 1'b0, 8'd4, ob(3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        // asynchronous reset mid-drive on channel 3
        for (int c = 0; c < 3; c++) chan($sformatf("rst_ch%0d", c), c == 0, 3'(c), 8'd1, 8'd1, 1'b0);
        cyc("rst_blank3", 1'b0, 1'b0, 1'b0, 8'd1, ob(3'd3, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("rst_drive3", 1'b0, 1'b0, 1'b0, 8'd1, ob(3'd3, 1'b1, 1'b1, 1'b1, 1'b0));
        #2 rst = 1'b1;
        #1 compare("async_reset", IDL);
        @(negedge clk);
        rst = 1'b0;
        cyc("rst_nodone0", 1'b0, 1'b0, 1'b0, 8'd1, IDL);
        cyc("rst_nodone1", 1'b0, 1'b0, 1'b0, 8'd1, IDL);
`ifdef SCAN_MASK_EN
        mask = 8'b1010_0001;
        chan("mask_ch0", 1'b1, 3'd0, 8'd1, 8'd1, 1'b0);
        chan("mask_ch5", 1'b0, 3'd5, 8'd1, 8'd1, 1'b0);
        chan("mask_ch7", 1'b0, 3'd7, 8'd1, 8'd1, 1'b0);
        cyc("mask_done", 1'b0, 1'b0, 1'b0, 8'd1, ob(3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        mask = 8'h00;
        cyc("mask_zero0", 1'b1, 1'b0, 1'b0, 8'd1, IDL);
        cyc("mask_zero1", 1'b1, 1'b0, 1'b0, 8'd1, IDL);
        mask = 8'hff;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
